// File: rtl/fpu_pkg.sv
// Shared FPU definitions: rounding modes, exception flags and binary32 classification.
package fpu_pkg;

  typedef enum logic [2:0] {
    RM_RNE = 3'd0,
    RM_RTZ = 3'd1,
    RM_RDN = 3'd2,
    RM_RUP = 3'd3,
    RM_RMM = 3'd4
  } rm_e;

  typedef struct packed {
    logic nv;
    logic nx;
  } fflags_t;

  localparam int F32_EXP_BIAS = 127;

  typedef enum logic [2:0] {
    F32_ZERO,
    F32_SUB,
    F32_NORM,
    F32_INF,
    F32_NAN
  } f32_class_e;

  function automatic f32_class_e f32_classify(input logic [31:0] f);
    if (f[30:23] == 8'hFF) begin
      return (f[22:0] == 23'd0) ? F32_INF : F32_NAN;
    end else if (f[30:23] == 8'h00) begin
      return (f[22:0] == 23'd0) ? F32_ZERO : F32_SUB;
    end
    return F32_NORM;
  endfunction

endpackage

// File: rtl/fcvt_round_inc.sv
// Rounding-increment decision from sign, result lsb, guard and sticky bits.
// Encodings 5..7 of rm fall into the default arm and truncate like RTZ.
module fcvt_round_inc
  import fpu_pkg::*;
(
  input  logic [2:0] rm,
  input  logic       sign,
  input  logic       lsb,
  input  logic       guard,
  input  logic       sticky,
  output logic       inc
);

  logic inexact;
  assign inexact = guard | sticky;

  // Pick the increment for the requested rounding direction.
  always_comb begin
    inc = 1'b0;
    case (rm)
      RM_RNE:  inc = guard & (sticky | lsb);
      RM_RDN:  inc = sign & inexact;
      RM_RUP:  inc = ~sign & inexact;
      RM_RMM:  inc = guard;
      default: inc = 1'b0;
    endcase
  end

endmodule

// File: rtl/fcvt_f2i_pipe.sv
// Pipelined float32 -> INT_W integer conversion with rounding modes, saturation,
// {NV,NX} flags, tag passthrough and valid/ready backpressure.
// Split: [opt input reg] A align [reg if STAGES>=2] B round [reg if STAGES>=3] C saturate [out reg].
module fcvt_f2i_pipe
  import fpu_pkg::*;
#(
  parameter int INT_W  = 32,
  parameter int STAGES = 3,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_f,
  input  logic [2:0]       in_rm,
  input  logic             in_unsigned,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [INT_W-1:0] out_i,
  output logic [1:0]       out_flags,
  output logic [TAG_W-1:0] out_tag
);

  // Integer field carries one headroom bit so e == INT_W still aligns exactly.
  localparam int IW = INT_W + 1;
  localparam int AW = IW + 23;
  localparam int MW = IW + 1;
  localparam logic signed [9:0] E_MAX = 10'(INT_W);
  localparam logic [MW-1:0] ONE_M = MW'(1);
  localparam logic [MW-1:0] S_LIM = ONE_M << (INT_W - 1);
  localparam logic [MW-1:0] U_MAX = (ONE_M << INT_W) - ONE_M;
  localparam logic [INT_W-1:0] S_MAX_I = {1'b0, {(INT_W-1){1'b1}}};
  localparam logic [INT_W-1:0] S_MIN_I = {1'b1, {(INT_W-1){1'b0}}};
  localparam logic [INT_W-1:0] U_MAX_I = {INT_W{1'b1}};

  typedef struct packed {
    logic             vld;
    logic [31:0]      f;
    logic [2:0]       rm;
    logic             uns;
    logic [TAG_W-1:0] tag;
  } in_t;

  typedef struct packed {
    logic             vld;
    logic             sign;
    logic             nan;
    logic             inf;
    logic             ovf;
    logic [IW-1:0]    ival;
    logic             grd;
    logic             stk;
    logic [2:0]       rm;
    logic             uns;
    logic [TAG_W-1:0] tag;
  } a_t;

  typedef struct packed {
    logic             vld;
    logic             sign;
    logic             nan;
    logic             inf;
    logic             ovf;
    logic [MW-1:0]    mag;
    logic             nx;
    logic             uns;
    logic [TAG_W-1:0] tag;
  } b_t;

  logic en;
  in_t  in_d, in_q;
  a_t   a_d, a_q;
  b_t   b_d, b_q;
  f32_class_e cls;
  logic signed [9:0] e_s;
  logic [AW-1:0] aligned;
  logic inc;
  logic too_big;
  logic             out_valid_d, out_valid_q;
  logic [INT_W-1:0] out_i_d, out_i_q;
  fflags_t          out_flags_d, out_flags_q;
  logic [TAG_W-1:0] out_tag_d, out_tag_q;

  // All stages advance together; a held result freezes the whole pipe, bubbles included.
  assign en       = ~(out_valid_q & ~out_ready);
  assign in_ready = en;

  // Bundle the offered op into the input payload.
  always_comb begin
    in_d.vld = in_valid;
    in_d.f   = in_f;
    in_d.rm  = in_rm;
    in_d.uns = in_unsigned;
    in_d.tag = in_tag;
  end

  if (STAGES == 4) begin : g_in_reg
    // Optional input register.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) in_q <= '0;
      else if (en) in_q <= in_d;
    end
  end else begin : g_in_pass
    assign in_q = in_d;
  end

  // Stage A: classify and align the significand into integer, guard and sticky.
  always_comb begin
    cls     = f32_classify(in_q.f);
    e_s     = $signed({2'b00, in_q.f[30:23]}) - $signed(10'(F32_EXP_BIAS));
    aligned = {{(IW-1){1'b0}}, 1'b1, in_q.f[22:0]} << e_s[6:0];
    a_d      = '0;
    a_d.vld  = in_q.vld;
    a_d.sign = in_q.f[31];
    a_d.nan  = (cls == F32_NAN);
    a_d.inf  = (cls == F32_INF);
    a_d.ovf  = (cls == F32_NORM) && (e_s > E_MAX);
    a_d.rm   = in_q.rm;
    a_d.uns  = in_q.uns;
    a_d.tag  = in_q.tag;
    case (cls)
      F32_NORM: begin
        if (!e_s[9]) begin
          a_d.ival = aligned[AW-1:23];
          a_d.grd  = aligned[22];
          a_d.stk  = |aligned[21:0];
        end else if (e_s == -10'sd1) begin
          a_d.grd = 1'b1;
          a_d.stk = |in_q.f[22:0];
        end else begin
          a_d.stk = 1'b1;
        end
      end
      F32_SUB: a_d.stk = 1'b1;
      default: ;
    endcase
  end

  if (STAGES >= 2) begin : g_a_reg
    // Register after alignment.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) a_q <= '0;
      else if (en) a_q <= a_d;
    end
  end else begin : g_a_pass
    assign a_q = a_d;
  end

  fcvt_round_inc u_round_inc (
    .rm     (a_q.rm),
    .sign   (a_q.sign),
    .lsb    (a_q.ival[0]),
    .guard  (a_q.grd),
    .sticky (a_q.stk),
    .inc    (inc)
  );

  // Stage B: apply the rounding increment to the magnitude.
  always_comb begin
    b_d      = '0;
    b_d.vld  = a_q.vld;
    b_d.sign = a_q.sign;
    b_d.nan  = a_q.nan;
    b_d.inf  = a_q.inf;
    b_d.ovf  = a_q.ovf;
    b_d.mag  = {1'b0, a_q.ival} + {{(MW-1){1'b0}}, inc};
    b_d.nx   = a_q.grd | a_q.stk;
    b_d.uns  = a_q.uns;
    b_d.tag  = a_q.tag;
  end

  if (STAGES >= 3) begin : g_b_reg
    // Register after rounding.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) b_q <= '0;
      else if (en) b_q <= b_d;
    end
  end else begin : g_b_pass
    assign b_q = b_d;
  end

  // Stage C: range check on the rounded magnitude, saturate, negate, flags.
  always_comb begin
    too_big     = 1'b0;
    out_i_d     = '0;
    out_flags_d = '0;
    out_valid_d = b_q.vld;
    out_tag_d   = b_q.tag;
    if (b_q.nan) begin
      out_flags_d.nv = 1'b1;
      out_i_d        = b_q.uns ? U_MAX_I : S_MAX_I;
    end else begin
      if (b_q.uns) begin
        too_big = b_q.inf | b_q.ovf | (b_q.sign ? (b_q.mag != '0) : (b_q.mag > U_MAX));
      end else begin
        too_big = b_q.inf | b_q.ovf | (b_q.sign ? (b_q.mag > S_LIM) : (b_q.mag >= S_LIM));
      end
      if (too_big) begin
        out_flags_d.nv = 1'b1;
        if (b_q.sign) out_i_d = b_q.uns ? '0 : S_MIN_I;
        else          out_i_d = b_q.uns ? U_MAX_I : S_MAX_I;
      end else begin
        out_flags_d.nx = b_q.nx;
        out_i_d = b_q.sign ? (~b_q.mag[INT_W-1:0] + {{(INT_W-1){1'b0}}, 1'b1})
                           : b_q.mag[INT_W-1:0];
      end
    end
  end

  // Output register, always present.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      out_i_q     <= '0;
      out_flags_q <= '0;
      out_tag_q   <= '0;
    end else if (en) begin
      out_valid_q <= out_valid_d;
      out_i_q     <= out_i_d;
      out_flags_q <= out_flags_d;
      out_tag_q   <= out_tag_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_i     = out_i_q;
  assign out_flags = out_flags_q;
  assign out_tag   = out_tag_q;

endmodule

// File: tb/tb_fcvt_f2i_pipe.sv
// Scoreboard bench for fcvt_f2i_pipe: a reference model computes each expected
// result when the op is accepted; the monitor pops and compares on output handshakes.
module tb_fcvt_f2i_pipe #(
  parameter int INT_W  = 32,
  parameter int STAGES = 3
);
  localparam int TAG_W = 5;
  localparam int NV = 21;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_ready;
  logic [31:0] in_f = '0;
  logic [2:0] in_rm = '0;
  logic in_unsigned = 1'b0;
  logic [TAG_W-1:0] in_tag = '0;
  logic out_valid;
  logic out_ready = 1'b1;
  logic [INT_W-1:0] out_i;
  logic [1:0] out_flags;
  logic [TAG_W-1:0] out_tag;

  typedef struct {
    logic [INT_W-1:0] i;
    logic [1:0]       fl;
    logic [TAG_W-1:0] tag;
    logic [31:0]      f;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int out_cyc = 0;
  logic [TAG_W-1:0] tag_ctr = '0;
  logic rand_done = 1'b0;

  // {f, rm, unsigned}
  localparam logic [35:0] VECS [0:NV-1] = '{
    {32'h40200000, 3'd0, 1'b0}, {32'h40200000, 3'd4, 1'b0},
    {32'h40200000, 3'd3, 1'b0}, {32'h40200000, 3'd2, 1'b0},
    {32'hC0200000, 3'd0, 1'b0}, {32'hC0200000, 3'd4, 1'b0},
    {32'hC0200000, 3'd1, 1'b0},
    {32'hCF000000, 3'd1, 1'b0}, {32'h4F000000, 3'd1, 1'b0},
    {32'h7FC00000, 3'd0, 1'b0}, {32'hFF800000, 3'd0, 1'b0},
    {32'hBF000000, 3'd1, 1'b1}, {32'hBF800000, 3'd1, 1'b1},
    {32'h4F800000, 3'd1, 1'b1}, {32'h00000001, 3'd3, 1'b1},
    {32'h3F000000, 3'd0, 1'b0}, {32'h3FC00000, 3'd0, 1'b0},
    {32'h80000000, 3'd0, 1'b1}, {32'hFFC00001, 3'd0, 1'b1},
    {32'h402CCCCD, 3'd6, 1'b0}, {32'hBF000000, 3'd2, 1'b1}
  };

  fcvt_f2i_pipe #(.INT_W(INT_W), .STAGES(STAGES), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_f(in_f), .in_rm(in_rm),
    .in_unsigned(in_unsigned), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i),
    .out_flags(out_flags), .out_tag(out_tag)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string name, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", name, obs, exp);
    end
  endtask

  // Reference: exact value as integer part plus remainder compared against one half.
  function automatic void model(input logic [31:0] f, input logic [2:0] rm, input logic uns,
                                output logic [INT_W-1:0] r, output logic [1:0] fl);
    logic sgn, big, gt, eq, inexact, up;
    int ex, p, sh;
    logic [127:0] mant, ip, rem, half, m, lim;
    logic [INT_W-1:0] smax, smin, umax;
    smax = {1'b0, {(INT_W-1){1'b1}}};
    smin = {1'b1, {(INT_W-1){1'b0}}};
    umax = '1;
    sgn = f[31];
    ex = int'(f[30:23]);
    big = 0; gt = 0; eq = 0; inexact = 0; ip = '0; up = 0;
    mant = (ex == 0) ? 128'(f[22:0]) : 128'({1'b1, f[22:0]});
    p = (ex == 0) ? -149 : ex - 150;
    if (ex == 255) begin
      if (f[22:0] != 0) begin
        r = uns ? umax : smax;
        fl = 2'b10;
        return;
      end
      big = 1;
    end else if (p >= 0) begin
      if (p > 70) big = 1;
      else ip = mant << p;
    end else begin
      sh = -p;
      if (sh >= 64) begin
        inexact = (mant != 0);
      end else begin
        ip = mant >> sh;
        rem = mant & ((128'd1 << sh) - 128'd1);
        half = 128'd1 << (sh - 1);
        gt = rem > half;
        eq = rem == half;
        inexact = rem != 0;
      end
    end
    case (rm)
      3'd0: up = gt | (eq & ip[0]);
      3'd2: up = sgn & inexact;
      3'd3: up = ~sgn & inexact;
      3'd4: up = gt | eq;
      default: up = 0;
    endcase
    m = ip + 128'(up);
    if (uns) lim = sgn ? 128'd0 : (128'd1 << INT_W) - 128'd1;
    else     lim = sgn ? (128'd1 << (INT_W - 1)) : (128'd1 << (INT_W - 1)) - 128'd1;
    if (big || m > lim) begin
      r = sgn ? (uns ? '0 : smin) : (uns ? umax : smax);
      fl = 2'b10;
    end else begin
      r = sgn ? INT_W'(-m) : INT_W'(m);
      fl = {1'b0, inexact};
    end
  endfunction

  // Drive one op; expectation is queued at the handshake.
  task automatic send(input logic [31:0] f, input logic [2:0] rm, input logic uns);
    exp_t e;
    int waited;
    logic ok;
    model(f, rm, uns, e.i, e.fl);
    e.tag = tag_ctr;
    e.f = f;
    in_valid = 1'b1; in_f = f; in_rm = rm; in_unsigned = uns; in_tag = tag_ctr;
    waited = 0;
    ok = 1'b0;
    while (!ok && waited < 100) begin
      @(negedge clk);
      if (in_ready) ok = 1'b1;
      waited++;
    end
    if (!ok) begin
      check_eq("accept_timeout", 64'(in_ready), 64'd1);
      in_valid = 1'b0;
      return;
    end
    sb.push_back(e);
    acc_cyc = cyc;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    tag_ctr = tag_ctr + 1'b1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    check_eq("drain_left", 64'(sb.size()), 64'd0);
    #1;
  endtask

  // Monitor: handshake ordering, in_ready rule, result compare.
  always @(negedge clk) begin
    if (!rst) begin
      check_eq("in_ready", 64'(in_ready), 64'(!(out_valid && !out_ready)));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check_eq("spurious_out", 64'(out_valid), 64'd0);
        end else begin
          mon_e = sb.pop_front();
          out_cyc = cyc;
          check_eq("out_i", 64'(out_i), 64'(mon_e.i));
          check_eq("out_flags", 64'(out_flags), 64'(mon_e.fl));
          check_eq("out_tag", 64'(out_tag), 64'(mon_e.tag));
          $display("op tag=%0d f=%h -> i=%h flags=%b (want %h %b)",
                   out_tag, mon_e.f, out_i, out_flags, mon_e.i, mon_e.fl);
        end
      end
    end
  end

  initial begin
    #1 rst = 1'b1;
    #2;
    check_eq("rst_valid", 64'(out_valid), 64'd0);
    check_eq("rst_i", 64'(out_i), 64'd0);
    check_eq("rst_flags", 64'(out_flags), 64'd0);
    check_eq("rst_tag", 64'(out_tag), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Latency from handshake cycle to first out_valid cycle.
    send(32'h40200000, 3'd0, 1'b0);
    drain();
    check_eq("latency", 64'(out_cyc - acc_cyc), 64'(STAGES));

    // Directed vectors, back to back.
    for (int k = 0; k < NV; k++) send(VECS[k][35:4], VECS[k][3:1], VECS[k][0]);
    drain();

    // Backpressure: 8 ops, out_ready low for 5 cycles mid-stream.
    fork
      begin
        for (int k = 0; k < 8; k++) send(32'h41000000 + 32'(k << 19), 3'(k % 5), 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain();

    // Random operands with random backpressure.
    rand_done = 1'b0;
    fork
      begin
        for (int k = 0; k < 40; k++) begin
          send({1'($urandom_range(0, 1)), 8'($urandom_range(120, 129 + INT_W)), 23'($urandom)},
               3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1 out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    out_ready = 1'b1;
    drain();

    // Async reset with three ops in flight.
    send(32'h40400000, 3'd0, 1'b0);
    send(32'hC0400000, 3'd0, 1'b0);
    send(32'h40800000, 3'd0, 1'b0);
    #1 rst = 1'b1;
    #1;
    check_eq("arst_valid", 64'(out_valid), 64'd0);
    check_eq("arst_i", 64'(out_i), 64'd0);
    check_eq("arst_flags", 64'(out_flags), 64'd0);
    check_eq("arst_tag", 64'(out_tag), 64'd0);
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (STAGES + 2) begin
      @(negedge clk);
      check_eq("post_rst_valid", 64'(out_valid), 64'd0);
    end
    send(32'hC0200000, 3'd4, 1'b0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
